// File: rtl/mux_pkg.sv
// Shared types and helpers for the mux serializer: FSM state encoding and
// select start/end positions for either bit order.
package mux_pkg;

  localparam int MUX_WIDTH = 8;
  localparam int MUX_SELW  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int unsigned sel_start(bit msb_first, int unsigned width);
    return msb_first ? width - 1 : 0;
  endfunction

  function automatic int unsigned sel_end(bit msb_first, int unsigned width);
    return msb_first ? 0 : width - 1;
  endfunction

endpackage

// File: rtl/mux_serializer_if.sv
// Load-side and serial-side handshake bundle for the mux serializer.
// slave = the serializer, master = the agent feeding and draining it.
interface mux_serializer_if #(
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(WIDTH)
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_data;
  logic             ser_last;
  logic [SELW-1:0]  sel;
  logic             busy;

  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_valid, ser_data, ser_last, sel, busy
  );

  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_valid, ser_data, ser_last, sel, busy
  );
endinterface

// File: rtl/mux_serializer_mux.sv
// Combinational m:1 bit-select mux with an n-bit select.
module mux_serializer_mux #(
  parameter int n = 3,
  parameter int m = 8
) (
  input  logic [m-1:0] data,
  input  logic [n-1:0] sel,
  output logic         out
);
  assign out = data[sel];
endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial front end: holds one word and walks the bit-select mux
// across it, one bit per accepted serial beat, with zero-bubble reload.
module mux_serializer
  import mux_pkg::*;
#(
  parameter int WIDTH     = MUX_WIDTH,
  parameter int SELW      = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input logic              clk,
  input logic              rst,
  mux_serializer_if.slave  bus
);

  localparam logic [SELW-1:0] START = SELW'(sel_start(MSB_FIRST, WIDTH));
  localparam logic [SELW-1:0] END   = SELW'(sel_end(MSB_FIRST, WIDTH));

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold_reg, hold_nxt;
  logic [SELW-1:0]  sel_q, sel_nxt;
  logic             mux_out;
  logic             at_end;
  logic             load_ready, ser_valid, ser_last, busy;

  assign at_end = (sel_q == END);

  // NOTE: non-blocking assignments keep every register updating from the
  // same pre-edge values, so the order of statements here cannot matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_reg <= '0;
      sel_q    <= '0;
    end else begin
      state    <= state_nxt;
      hold_reg <= hold_nxt;
      sel_q    <= sel_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_reg;
    sel_nxt    = sel_q;
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (bus.load_valid) begin
          hold_nxt  = bus.load_data;
          sel_nxt   = START;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_last  = at_end;
        if (bus.ser_ready) begin
          if (!at_end) begin
            sel_nxt = MSB_FIRST ? sel_q - SELW'(1) : sel_q + SELW'(1);
          end else begin
            // Final bit leaves this cycle: take the next word with no bubble.
            load_ready = 1'b1;
            if (bus.load_valid) begin
              hold_nxt = bus.load_data;
              sel_nxt  = START;
            end else begin
              sel_nxt   = '0;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  mux_serializer_mux #(
    .n (SELW),
    .m (WIDTH)
  ) u_mux (
    .data (hold_reg),
    .sel  (sel_q),
    .out  (mux_out)
  );

  assign bus.load_ready = load_ready;
  assign bus.ser_valid  = ser_valid;
  assign bus.ser_data   = ser_valid & mux_out;
  assign bus.ser_last   = ser_last;
  assign bus.sel        = sel_q;
  assign bus.busy       = busy;

endmodule
